// File: rtl/uart_cmd_tx.sv
// rtl/uart_cmd_tx.sv - FIFO-buffered 8N1 UART transmitter, LSB first.
// Define UART_CMD_TX_STOP2_EN for two stop bits (11-bit frames).
module uart_cmd_tx #(
  parameter int UART_CLK_TICKS_PER_BIT = 65,
  parameter int FIFO_DEPTH             = 16
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic [7:0]                  data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  output logic                        tx_out,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [7:0]                  bytes_sent
);

  localparam int CW = $clog2(UART_CLK_TICKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(UART_CLK_TICKS_PER_BIT - 1);
  localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);
`ifdef UART_CMD_TX_STOP2_EN
  localparam logic [2:0] STOP_LAST = 3'd1;
`else
  localparam logic [2:0] STOP_LAST = 3'd0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_out_q, tx_out_d;
  logic [7:0]      bytes_sent_q, bytes_sent_d;
  logic [NW-1:0]   fifo_count_q, fifo_count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic            push, pop, last_tick;

  assign data_ready = (fifo_count_q != CNT_FULL);
  assign tx_busy    = (state_q != S_IDLE) || (fifo_count_q != '0);
  assign tx_out     = tx_out_q;
  assign fifo_count = fifo_count_q;
  assign bytes_sent = bytes_sent_q;

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr_q] <= data_in;
  end

  always_comb begin
    push         = data_valid && data_ready;
    pop          = 1'b0;
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    bytes_sent_d = bytes_sent_q;
    last_tick    = (tick_q == TICK_LAST);
    tick_d       = last_tick ? '0 : tick_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (fifo_count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (last_tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (last_tick) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = S_STOP;
          end
        end
      end
      S_STOP: begin
        // bit_idx counts stop bits here so the tick counter never needs to exceed one bit period
        if (last_tick) begin
          if (bit_idx_q == STOP_LAST) begin
            bytes_sent_d = bytes_sent_q + 8'd1;
            if (fifo_count_q != '0) pop = 1'b1;
            else                    state_d = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d   = fifo_mem[rd_ptr_q];
      bit_idx_d = 3'd0;
      state_d   = S_START;
    end

    tx_out_d = 1'b1;
    if (state_q == S_START)     tx_out_d = 1'b0;
    else if (state_q == S_DATA) tx_out_d = shift_q[0];

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + NW'(1);
      2'b01:   fifo_count_d = fifo_count_q - NW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= S_IDLE;
      tick_q       <= '0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      tx_out_q     <= 1'b1;
      bytes_sent_q <= 8'd0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      tx_out_q     <= tx_out_d;
      bytes_sent_q <= bytes_sent_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// tb/tb_uart_cmd_tx.sv - self-checking bench for uart_cmd_tx.
// A serial-line decoder compares every frame against the queue of accepted bytes.
module tb_uart_cmd_tx;

  localparam int T     = 65;
  localparam int DEPTH = 16;
`ifdef UART_CMD_TX_STOP2_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * T;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'd0;
  logic       data_valid = 1'b0;
  logic       data_ready, tx_out, tx_busy;
  logic [4:0] fifo_count;
  logic [7:0] bytes_sent;

  uart_cmd_tx #(.UART_CLK_TICKS_PER_BIT(T), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .tx_out(tx_out), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .bytes_sent(bytes_sent)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  // reference model: bytes accepted by the handshake, in order, and frames completed
  logic [7:0] exp_q[$];
  int         fall_q[$];
  int         sent_model = 0;

  // line decoder: start bit on falling edge, sample each bit mid-period
  bit          mon_active = 0;
  int          mon_t = 0;
  int          unstable = 0;
  logic        bit_first = 1'b1;
  logic [10:0] frame_bits = '0;

  initial begin
    forever begin
      @(posedge clk_in);
      #2;
      if (reset) begin
        mon_active = 0;
      end else if (!mon_active) begin
        if (tx_out === 1'b0) begin
          mon_active = 1;
          mon_t      = 0;
          unstable   = 0;
          fall_q.push_back(cyc);
        end
      end else begin
        mon_t++;
      end
      if (mon_active && !reset) begin
        if (mon_t % T == 0) bit_first = tx_out;
        else if (tx_out !== bit_first) unstable++;
        if (mon_t % T == T / 2) frame_bits[mon_t / T] = tx_out;
        if (mon_t == FRAME - 1) begin
          logic [31:0] exp_val;
          logic        stop_ok;
          mon_active = 0;
          stop_ok = 1'b1;
          for (int i = 9; i < NBITS; i++) if (frame_bits[i] !== 1'b1) stop_ok = 1'b0;
          exp_val = 32'h100;
          if (exp_q.size() != 0) exp_val = {24'd0, exp_q.pop_front()};
          check_eq("start_bit", {31'd0, frame_bits[0]}, 32'd0);
          check_eq("stop_bit", {31'd0, stop_ok}, 32'd1);
          check_eq("bit_stable", unstable, 0);
          check_eq("rx_byte", {24'd0, frame_bits[8:1]}, exp_val);
          sent_model++;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    int n = 0;
    data_in    = b;
    data_valid = 1'b1;
    while (!data_ready && n < 5000) begin
      step();
      n++;
    end
    exp_q.push_back(b);
    step();
    data_valid = 1'b0;
    check_eq("push_wait", {31'd0, n >= 5000}, 32'd0);
  endtask

  task automatic wait_drain(input string tag);
    int t0 = cyc;
    while ((tx_busy || exp_q.size() != 0) && cyc < t0 + 25000) step();
    step();
    check_eq(tag, exp_q.size(), 0);
    check_eq({tag, "_sent"}, bytes_sent, sent_model[7:0]);
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int f0, n, acc, bad, t0;

    reset = 1'b1;
    step();
    step();
    check_eq("rst_tx_out", {31'd0, tx_out}, 32'd1);
    check_eq("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("rst_fifo_count", fifo_count, 0);
    check_eq("rst_data_ready", {31'd0, data_ready}, 32'd1);
    check_eq("rst_bytes_sent", bytes_sent, 0);
    reset = 1'b0;
    step();

    // single byte 'L': pop at N+1, start bit at N+2
    data_in = 8'h4C;
    data_valid = 1'b1;
    exp_q.push_back(8'h4C);
    step();
    data_valid = 1'b0;
    check_eq("push_count", fifo_count, 1);
    step();
    check_eq("pop_line_idle", {31'd0, tx_out}, 32'd1);
    check_eq("pop_count", fifo_count, 0);
    step();
    check_eq("start_fall", {31'd0, tx_out}, 32'd0);
    f0 = cyc;
    step_to(f0 + T - 1);
    check_eq("start_hold", {31'd0, tx_out}, 32'd0);
    step_to(f0 + FRAME - 5);
    check_eq("sent_before_end", bytes_sent, 0);
    step_to(f0 + FRAME);
    check_eq("sent_after_end", bytes_sent, 1);
    check_eq("idle_after_single", {31'd0, tx_busy}, 32'd0);

    // back-to-back frames with no idle gap
    fall_q.delete();
    data_in = 8'h62;
    data_valid = 1'b1;
    exp_q.push_back(8'h62);
    step();
    data_in = 8'h72;
    exp_q.push_back(8'h72);
    step();
    data_valid = 1'b0;
    n = 0;
    while (fall_q.size() == 0 && n < 20) begin
      step();
      n++;
    end
    check_eq("b2b_first_fall", {31'd0, fall_q.size() != 0}, 32'd1);
    f0 = (fall_q.size() != 0) ? fall_q[0] : cyc;
    bad = 0;
    while (cyc < f0 + 2 * FRAME - 2) begin
      if (!tx_busy) bad++;
      step();
    end
    check_eq("b2b_busy_held", bad, 0);
    step_to(f0 + 2 * FRAME);
    check_eq("b2b_busy_fall", {31'd0, tx_busy}, 32'd0);
    check_eq("b2b_gap", (fall_q.size() == 2) ? fall_q[1] - fall_q[0] : -1, FRAME);
    check_eq("b2b_sent", bytes_sent, 3);

    // overflow: 20 distinct bytes offered one per cycle, valid held
    acc = 0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      data_in = 8'hA0 + 8'(k);
      data_valid = 1'b1;
      if (data_ready) begin
        exp_q.push_back(data_in);
        acc++;
      end
      step();
      if (fifo_count == 5'(DEPTH) && data_ready) bad++;
    end
    data_valid = 1'b0;
    check_eq("ovf_accepted", acc, 17);
    check_eq("ovf_full_count", fifo_count, DEPTH);
    check_eq("ovf_ready_low", {31'd0, data_ready}, 32'd0);
    check_eq("ovf_ready_with_full", bad, 0);
    wait_drain("ovf_drain");
    check_eq("ovf_total_sent", bytes_sent, 20);

    // reset in the middle of DATA with bytes still queued
    push(8'h55);
    push(8'h11);
    push(8'h22);
    t0 = cyc;
    while (tx_out !== 1'b0 && cyc < t0 + 20) step();
    f0 = cyc;
    step_to(f0 + 3 * T + 10);
    reset = 1'b1;
    exp_q.delete();
    sent_model = 0;
    step();
    reset = 1'b0;
    check_eq("midrst_tx_out", {31'd0, tx_out}, 32'd1);
    check_eq("midrst_count", fifo_count, 0);
    check_eq("midrst_sent", bytes_sent, 0);
    check_eq("midrst_ready", {31'd0, data_ready}, 32'd1);
    check_eq("midrst_busy", {31'd0, tx_busy}, 32'd0);
    step();
    step();
    push(8'h3C);
    wait_drain("midrst_drain");
    check_eq("midrst_one_frame", bytes_sent, 1);

    // random bytes with random gaps and short bursts
    for (int k = 0; k < 8; k++) begin
      push(8'($urandom));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
    end
    wait_drain("rand_drain");
    check_eq("rand_idle_line", {31'd0, tx_out}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
